cmd_sequencer: RTL
==================

Name: cmd_sequencer

Overview:
- Upstream command stage for the 4-bit load/double/increment register stage.
- Buffers commands from a valid/ready producer in a small FIFO.
- Expands each command into a registered {control, data} drive word, held for a programmable number of consecutive cycles.
- Outputs connect directly to the downstream stage's data_in[3:0] and control[2:0].

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- AW, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  producer presents a command.
- in_ready  output  1  FIFO can accept; equals !full.
- in_op  input  2  00 HOLD, 01 LOAD, 10 LOAD2X, 11 INC.
- in_data  input  4  operand for LOAD / LOAD2X.
- in_rep  input  3  issue count minus 1 (0 gives 1 cycle, 7 gives 8 cycles).
- pause  input  1  freezes issuing.
- ctrl_out  output  3  to downstream control; bit0 enable, bit1 double, bit2 increment.
- data_out  output  4  to downstream data_in.
- busy  output  1  FIFO non-empty or issue in progress.
- level  output  AW+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - FIFO empty, pointers 0, level 0.
  - State IDLE, repeat counter 0.
  - ctrl_out 000, data_out 0000, busy 0, in_ready 1.
- Push: a command is written on a clk edge where in_valid && in_ready. There is no pass-through; a pushed command is stored first.
- Op to drive word mapping:
  - HOLD gives ctrl 000, data 0000.
  - LOAD gives ctrl 001, data in_data.
  - LOAD2X gives ctrl 011, data in_data.
  - INC gives ctrl 101, data 0000.
- FSM, IDLE:
  - ctrl_out is 000 and data_out is 0000.
  - If FIFO non-empty and !pause: pop the head and load the drive word into the output registers. Load in_rep into the counter and go to ISSUE.
- FSM, ISSUE:
  - The drive word is held each cycle.
  - Each un-paused cycle with counter > 0 decrements the counter.
  - On an un-paused cycle with counter == 0 (last repetition):
    - If FIFO non-empty, pop the next command and load it at the same edge. Commands issue back-to-back with no bubble.
    - Otherwise return to IDLE and drive ctrl 000 from the next cycle.
- Pause:
  - While pause=1, ctrl_out is forced to 000 combinationally. Counter, state, FIFO head and data_out are frozen.
  - Pushes are still accepted while paused.
  - The paused cycle does not count as a repetition.
- Latency: a push at edge N into an empty, idle sequencer gives the first drive cycle N+1 to N+2. ctrl_out is valid after edge N+1.
- Boundary conditions:
  - Full: in_ready=0. A push attempt is ignored and producer data is not sampled.
  - Simultaneous push and pop on the same edge: both take effect and level is unchanged.
  - Pointers wrap modulo DEPTH.
  - Reset mid-issue: FIFO contents are discarded and outputs go immediately to reset values.
- busy = (level != 0) || (state == ISSUE).

Optional Feature:
- Macro: CMD_SEQ_SHADOW_EN.
- When defined:
  - Extra output shadow[3:0] mirrors the downstream register's value.
  - Reset value is 0.
  - Updates on every edge from the effective ctrl_out/data_out: enable=0 holds; inc adds 1 mod 16; double gives (data*2) mod 16; otherwise loads data.
- When not defined: the port and its logic are absent and the rest of the behaviour is unchanged.

Test Plan:
- Reset, then idle: ctrl_out=000, data_out=0, in_ready=1, busy=0, level=0.
- Push LOAD data=5 rep=0 -> ctrl_out=001, data_out=5 for exactly 1 cycle starting one cycle after push, then 000. Shadow=5.
- Push back-to-back LOAD 3 rep=0, then INC rep=2 -> 001/3 for 1 cycle, then 101 for 3 cycles with no gap. Shadow sequence 3,4,5,6.
- Push LOAD2X data=9 rep=0 -> ctrl 011, data 9. Shadow=2 (18 mod 16).
- Push 5 commands with rep=7 while issuing is paused:
  - in_ready drops after 4 pushes (DEPTH=4) and level=4.
  - The 5th push is held until a pop frees a slot.
- Mid-issue of INC rep=7, pause high 2 cycles -> ctrl 000 during pause; 8 total INC cycles still issued.
- Assert rst during ISSUE with level=3 -> outputs 000/0 immediately, level=0, busy=0. No stale command issues after release.

Source files
------------

// File: rtl/cmd_sequencer.sv
// Command sequencer: buffers {op, data, rep} commands in a FIFO and replays each as a held {control, data} drive word.
// Optional CMD_SEQ_SHADOW_EN adds a shadow output that mirrors the downstream 4-bit register.
module cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [3:0]    in_data,
    input  logic [2:0]    in_rep,
    input  logic          pause,
    output logic [2:0]    ctrl_out,
    output logic [3:0]    data_out,
    output logic          busy,
    output logic [AW:0]   level
`ifdef CMD_SEQ_SHADOW_EN
    ,
    output logic [3:0]    shadow
`endif
);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    localparam logic [1:0]  OP_LOAD   = 2'b01;
    localparam logic [1:0]  OP_LOAD2X = 2'b10;
    localparam logic [1:0]  OP_INC    = 2'b11;
    localparam logic [AW:0] FULL_LVL  = (AW + 1)'(DEPTH);

    state_t        state;
    state_t        next_state;
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [2:0]    cnt;
    logic [2:0]    ctrl_reg;
    logic [3:0]    data_reg;
    logic          push;
    logic          pop;
    logic          dec;
    logic          empty;
    logic [8:0]    head;
    logic [2:0]    head_ctrl;
    logic [3:0]    head_data;

    // Handshake: a command transfers on a rising edge where in_valid && in_ready.
    assign in_ready = (level != FULL_LVL);
    assign empty    = (level == '0);
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];

    always_comb begin
        head_ctrl = 3'b000;
        head_data = 4'b0000;
        case (head[8:7])
            OP_LOAD:   begin head_ctrl = 3'b001; head_data = head[6:3]; end
            OP_LOAD2X: begin head_ctrl = 3'b011; head_data = head[6:3]; end
            OP_INC:    head_ctrl = 3'b101;
            default:   head_ctrl = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_op, in_data, in_rep};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // A pop on the last repetition chains the next command with no idle cycle between them.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        dec        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !pause) begin
                    pop        = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (!pause) begin
                    if (cnt != 3'd0)  dec = 1'b1;
                    else if (!empty)  pop = 1'b1;
                    else              next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_reg <= 3'b000;
            data_reg <= 4'b0000;
            cnt      <= 3'd0;
        end else if (pop) begin
            ctrl_reg <= head_ctrl;
            data_reg <= head_data;
            cnt      <= head[2:0];
        end else if (dec) begin
            cnt <= cnt - 3'd1;
        end else if (state == ISSUE && next_state == IDLE) begin
            ctrl_reg <= 3'b000;
            data_reg <= 4'b0000;
        end
    end

    always_comb begin
        ctrl_out = pause ? 3'b000 : ctrl_reg;
        data_out = data_reg;
        busy     = !empty || (state == ISSUE);
    end

`ifdef CMD_SEQ_SHADOW_EN
    // Increment takes priority over double, matching the downstream register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= 4'd0;
        end else if (ctrl_out[0]) begin
            if (ctrl_out[2])      shadow <= shadow + 4'd1;
            else if (ctrl_out[1]) shadow <= {data_out[2:0], 1'b0};
            else                  shadow <= data_out;
        end
    end
`endif

endmodule
